div_ctrl: RTL and testbench
===========================

// Module: div_ctrl
// PURPOSE
//  Multi-cycle divide/remainder controller beside the EX stage, for RV32M DIV/DIVU/REM/REMU.
//  EX issues a request; this block sequences a radix-2 restoring divider over XLEN iterations.
//  It asserts busy_o so ctrl holds the front pipeline, then returns one write-back beat
//  (rd_addr_o/rd_data_o/rd_wen_o) to regs. A jump/flush from ctrl cancels an in-flight operation.
// PARAMETERS
//  XLEN    32  operand/result width
//  CNT_W   6   iteration counter width (must hold XLEN)
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  start_i      in   1     request valid from EX (one-cycle pulse)
//  op_i         in   3     funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  dividend_i   in   XLEN  rs1 value
//  divisor_i    in   XLEN  rs2 value
//  rd_addr_i    in   5     destination register
//  flush_i      in   1     cancel (jump_en from ctrl)
//  busy_o       out  1     hold request to ctrl
//  rd_data_o    out  XLEN  result
//  rd_addr_o    out  5     write-back address
//  rd_wen_o     out  1     write-back enable, one-cycle pulse
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; count, operand and result regs cleared.
//  States: IDLE -> CALC -> DONE -> IDLE. Encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
//  IDLE: on start_i & ~flush_i latch op, rd_addr, |dividend|, |divisor| (abs only for signed ops),
//   and result sign: quotient neg = dividend[31]^divisor[31] (DIV), remainder neg = dividend[31] (REM).
//   - divisor==0: go DONE next cycle; result quotient=32'hFFFF_FFFF, remainder=dividend_i.
//   - DIV/REM with dividend=32'h8000_0000, divisor=32'hFFFF_FFFF: DONE next cycle;
//     quotient=32'h8000_0000, remainder=0.
//   - otherwise: count=0, rem=0, go CALC.
//  CALC: each cycle shift {rem,quot} left 1; if shifted rem >= divisor, subtract and set quot[0].
//   count++; after iteration XLEN-1 (count==XLEN-1) go DONE. Exactly XLEN cycles in CALC.
//  DONE: one cycle; rd_wen_o=1, rd_addr_o=latched rd, rd_data_o=quot or rem per op, negated
//   (two's complement) when sign flag set; then IDLE. Outputs are registered: rd_wen_o high only in DONE.
//  Latency: start at edge N -> rd_wen_o high during cycle N+XLEN+1 (33 for XLEN=32);
//   special cases (div-by-zero, overflow) -> rd_wen_o high in cycle N+1.
//  busy_o combinational: (IDLE & start_i & ~flush_i) | CALC. Low in DONE so the pipeline
//   releases as write-back occurs.
//  flush_i: in any state, next state IDLE, rd_wen_o forced 0 that cycle and the next; no write-back.
//   flush_i together with start_i in IDLE: request ignored.
//  start_i while CALC/DONE: ignored (ctrl holds EX, so this indicates an upstream bug).
//  Reset mid-CALC: immediate IDLE, no write-back, busy_o=0.
//  Width rules: rem register is XLEN+1 bits for compare/subtract; count saturates at XLEN-1.
// STRUCTURE
//  defines.v gains: `INST_DIV/`INST_DIVU/`INST_REM/`INST_REMU (funct3) and `INST_TYPE_M funct7 7'b0000001.
//  State encodings are localparams here.
//  One sub-module div_step (combinational): inputs rem, quot, divisor; outputs the next rem and quot;
//  instantiated once in CALC.
// TESTING
//  DIVU 100/7 -> rd_wen_o in cycle 33 after start, rd_data=14; REMU 100/7 -> 2; busy_o high cycles 0..32.
//  DIV -20/3 -> 0xFFFF_FFFA (-6); REM -20/3 -> 0xFFFF_FFFE (-2); DIV 20/-3 -> -6.
//  DIVU 5/0 -> 0xFFFF_FFFF one cycle after start; REM 5/0 -> 5; busy_o high only in the start cycle.
//  DIV 0x8000_0000/-1 -> 0x8000_0000, REM -> 0, both in 1 cycle.
//  Start DIVU, assert flush_i at cycle 10 -> IDLE next cycle, rd_wen_o never rises;
//   a new start at cycle 12 completes normally.
//  Deassert rst_n at cycle 15 of CALC -> outputs 0 immediately; start_i pulse while CALC ignored.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared types and funct3 decoding for the RV32M divide/remainder controller.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    function automatic logic op_signed(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_rem(input logic [2:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide iteration: shift {rem,quot} left, then trial-subtract the divisor.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] quot_next
);

    logic [XLEN:0] shifted;
    logic          ge;

    always_comb begin
        shifted = {rem[XLEN-1:0], quot[XLEN-1]};
        // A set top bit means the shifted value already exceeds any XLEN-bit divisor.
        ge        = rem[XLEN] | (shifted >= {1'b0, divisor});
        rem_next  = ge ? (shifted - {1'b0, divisor}) : shifted;
        quot_next = {quot[XLEN-2:0], ge};
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: holds the pipeline via busy_o, then emits one
// registered write-back beat. Division runs on magnitudes; the sign is restored at the end.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wen_o
);

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [XLEN:0]     rem;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   divisor;
    logic              rem_sel;
    logic              neg;
    logic              wen_q;

    logic              accept;
    logic              is_signed;
    logic              is_rem;
    logic              last;
    logic [XLEN-1:0]   dvd_abs;
    logic [XLEN-1:0]   dvs_abs;
    logic [XLEN:0]     step_rem;
    logic [XLEN-1:0]   step_quot;
    logic [XLEN-1:0]   result;

    div_step #(.XLEN(XLEN)) u_step (
        .rem       (rem),
        .quot      (quot),
        .divisor   (divisor),
        .rem_next  (step_rem),
        .quot_next (step_quot)
    );

    always_comb begin
        accept    = (state == IDLE) && start_i && !flush_i;
        is_signed = op_signed(op_i);
        is_rem    = op_rem(op_i);
        dvd_abs   = (is_signed && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
        dvs_abs   = (is_signed && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
        last      = (count == LAST_CNT);
        result    = rem_sel ? step_rem[XLEN-1:0] : step_quot;
        busy_o    = accept || (state == CALC);
        // A flush in DONE must suppress the beat that is already registered.
        rd_wen_o  = wen_q && !flush_i;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            rem       <= '0;
            quot      <= '0;
            divisor   <= '0;
            rem_sel   <= 1'b0;
            neg       <= 1'b0;
            wen_q     <= 1'b0;
            rd_data_o <= '0;
            rd_addr_o <= '0;
        end else if (flush_i) begin
            state <= IDLE;
            wen_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    wen_q <= 1'b0;
                    if (accept) begin
                        rem_sel   <= is_rem;
                        rd_addr_o <= rd_addr_i;
                        neg       <= is_signed && (is_rem ? dividend_i[XLEN-1]
                                                          : dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                        if (divisor_i == '0) begin
                            rd_data_o <= is_rem ? dividend_i : '1;
                            wen_q     <= 1'b1;
                            state     <= DONE;
                        end else if (is_signed && dividend_i == INT_MIN && divisor_i == '1) begin
                            rd_data_o <= is_rem ? '0 : INT_MIN;
                            wen_q     <= 1'b1;
                            state     <= DONE;
                        end else begin
                            count   <= '0;
                            rem     <= '0;
                            quot    <= dvd_abs;
                            divisor <= dvs_abs;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= step_rem;
                    quot  <= step_quot;
                    count <= last ? count : count + 1'b1;
                    if (last) begin
                        rd_data_o <= neg ? -result : result;
                        wen_q     <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    wen_q <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    wen_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: results, latency, busy window, flush, reset and ignored starts.
module tb_div_ctrl;

    localparam logic [2:0] DIV  = 3'b100;
    localparam logic [2:0] DIVU = 3'b101;
    localparam logic [2:0] REM  = 3'b110;
    localparam logic [2:0] REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  rd_addr;
    logic        flush;
    logic        busy;
    logic [31:0] rd_data;
    logic [4:0]  rd_addr_q;
    logic        rd_wen;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    div_ctrl #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .op_i       (op),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .rd_addr_i  (rd_addr),
        .flush_i    (flush),
        .busy_o     (busy),
        .rd_data_o  (rd_data),
        .rd_addr_o  (rd_addr_q),
        .rd_wen_o   (rd_wen)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Presents a one-cycle request starting at a falling edge; returns at the next falling edge (k=1).
    task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        start = 1'b1; op = o; dividend = a; divisor = b; rd_addr = rd;
        #1 check({tag, " busy_start"}, 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Watches falling edges k0..45 for the write-back beat; lat stays 0 if it never comes.
    task automatic wait_wen(input int k0, output int lat, output int busy_cnt,
                            output logic [31:0] data, output logic [4:0] addr);
        lat = 0; busy_cnt = 0; data = '0; addr = '0;
        for (int k = k0; k <= 45; k++) begin
            if (k > k0) @(negedge clk);
            #1;
            if (rd_wen) begin
                lat = k; data = rd_data; addr = rd_addr_q;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_data, input int exp_lat);
        int          lat;
        int          busy_cnt;
        logic [31:0] data;
        logic [4:0]  addr;
        issue(tag, o, a, b, rd);
        wait_wen(1, lat, busy_cnt, data, addr);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " data"}, data, exp_data);
        check({tag, " addr"}, 32'(addr), 32'(rd));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        @(negedge clk);
        #1 check({tag, " wen_pulse"}, 32'(rd_wen), 32'd0);
    endtask

    initial begin
        int          lat;
        int          busy_cnt;
        int          wen_seen;
        logic [31:0] data;
        logic [4:0]  addr;

        rst_n = 1'b0; start = 1'b0; op = DIVU; dividend = '0; divisor = '0;
        rd_addr = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset wen", 32'(rd_wen), 32'd0);
        check("reset data", rd_data, 32'd0);
        check("reset addr", 32'(rd_addr_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("divu 100/7", DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);
        run_op("remu 100/7", REMU, 32'd100, 32'd7, 5'd6, 32'd2, 33);
        run_op("div -20/3", DIV, 32'hFFFF_FFEC, 32'd3, 5'd7, 32'hFFFF_FFFA, 33);
        run_op("rem -20/3", REM, 32'hFFFF_FFEC, 32'd3, 5'd8, 32'hFFFF_FFFE, 33);
        run_op("div 20/-3", DIV, 32'd20, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFFA, 33);
        run_op("divu max/1", DIVU, 32'hFFFF_FFFF, 32'd1, 5'd10, 32'hFFFF_FFFF, 33);
        run_op("divu 5/0", DIVU, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
        run_op("rem 5/0", REM, 32'd5, 32'd0, 5'd12, 32'd5, 1);
        run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
        run_op("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 1);

        // Flush at cycle 10 of a DIVU, then restart at cycle 12.
        issue("flush op", DIVU, 32'd100, 32'd7, 5'd15);
        wen_seen = 0;
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            #1 if (rd_wen) wen_seen++;
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush wen_same_cycle", 32'(rd_wen), 32'd0);
        check("flush busy_calc", 32'(busy), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush idle_busy", 32'(busy), 32'd0);
        check("flush wen_next", 32'(rd_wen), 32'd0);
        check("flush no_wen_before", 32'(wen_seen), 32'd0);
        run_op("after flush 200/9", DIVU, 32'd200, 32'd9, 5'd16, 32'd22, 33);

        // Start together with flush in IDLE is ignored.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = DIVU; dividend = 32'd100; divisor = 32'd7; rd_addr = 5'd17;
        #1 check("start+flush busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("start+flush stays idle", 32'(busy), 32'd0);
        check("start+flush no wen", 32'(rd_wen), 32'd0);

        // A second start during CALC must not disturb the running operation.
        issue("busy op", DIVU, 32'd100, 32'd7, 5'd18);
        repeat (4) @(negedge clk);
        start = 1'b1; op = DIVU; dividend = 32'd9; divisor = 32'd3; rd_addr = 5'd3;
        #1 check("ignored start busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_wen(6, lat, busy_cnt, data, addr);
        check("ignored start latency", 32'(lat), 32'd33);
        check("ignored start data", data, 32'd14);
        check("ignored start addr", 32'(addr), 32'd18);

        // Reset asserted in cycle 15 of CALC.
        issue("reset op", DIVU, 32'd100, 32'd7, 5'd19);
        repeat (14) @(negedge clk);
        #1 check("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset wen", 32'(rd_wen), 32'd0);
        check("mid reset data", rd_data, 32'd0);
        check("mid reset addr", 32'(rd_addr_q), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wen_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1 if (rd_wen || busy) wen_seen++;
        end
        check("post reset quiet", 32'(wen_seen), 32'd0);

        run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 5'd20, 32'hFFFF_FFFD, 33);
        run_op("rem 7/-2", REM, 32'd7, 32'hFFFF_FFFE, 5'd21, 32'd1, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
